skew_feed_buffer: RTL
=====================

// Module: skew_feed_buffer
// PURPOSE
//  Ping-pong input staging buffer directly upstream of skew_registers.
//  - Accepts a serial word stream (valid/ready) and fills one of two banks of DEPTH N-wide vectors.
//  - Streams a full bank out one vector per cycle on dout/dout_en, which drive skew_registers din/en.
//  - Appends N-1 zero vectors so the skew chain drains completely.
// PARAMETERS
//  DATA_WIDTH  16  bits per word/lane
//  N           4   lanes per vector; must equal skew_registers N
//  DEPTH       8   vectors per tile (bank); power of 2, >=2
// PORTS
//  clk        in   1              single clock; all logic on posedge
//  rst        in   1              synchronous, active-high reset
//  wr_valid   in   1              write word valid
//  wr_ready   out  1              buffer can accept a write word
//  wr_data    in   DATA_WIDTH     write word, signed
//  rd_start   in   1              request to stream the next full bank
//  rd_stall   in   1              freeze the read side this cycle
//  rd_busy    out  1              read FSM not IDLE
//  tile_done  out  1              1-cycle pulse when a tile, including drain, has finished
//  dout       out  DATA_WIDTH x N signed unpacked array [N-1:0] to skew_registers din
//  dout_en    out  1              vector valid; drives skew_registers en
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  Reset clears all control state; bank storage is not reset.
//   - Reset values: wr_bank=0, rd_bank=0, full[1:0]=0, wr_cnt=0, FSM=IDLE.
//   - Outputs after reset: dout=0, dout_en=0, tile_done=0, rd_busy=0.
//   - wr_ready=0 while rst is high.
//   - Reset asserted mid-operation aborts the tile; no tile_done is produced.
//  Write side:
//   - A word is accepted when wr_valid & wr_ready; wr_ready = !rst & !full[wr_bank].
//   - Word k (0..N*DEPTH-1) is stored at vector k/N, lane k%N; wr_cnt width is $clog2(N*DEPTH).
//   - On the last word, full[wr_bank] sets, wr_bank toggles and wr_cnt wraps to 0, all on the same edge.
//  Read FSM: IDLE -> STREAM -> DRAIN -> IDLE.
//   - IDLE: rd_start & full[rd_bank] moves to STREAM with vec=0.
//     rd_start is otherwise ignored; requests are not queued.
//   - STREAM: dout is registered. The cycle after acceptance shows dout=bank[rd_bank][0], dout_en=1.
//     Vector i appears at cycle i+1; after DEPTH vectors, go to DRAIN.
//   - DRAIN: N-1 cycles of dout=0, dout_en=1 (0 cycles if N=1).
//   - On the final DRAIN cycle: clear full[rd_bank], toggle rd_bank, pulse tile_done for 1 cycle, return to IDLE.
//   - Tile latency: DEPTH+N-1 enabled cycles; tile_done is coincident with the last dout_en.
//   - rd_stall=1 in STREAM/DRAIN: the next edge shows dout_en=0, dout holds its value and the counters hold.
//     No vector is skipped or repeated. rd_stall is ignored in IDLE.
//  Simultaneous events:
//   - Write completion and rd_start on the same cycle: rd_start sees the old full (0) and is ignored.
//   - A freed bank shows wr_ready=1 on the cycle after tile_done.
//   - Reads and writes never target the same bank at once, because wr_ready is gated by full.
//  Signed data passes through unchanged; no arithmetic.
// STRUCTURE
//  Shared package dnn_pkg:
//   - typedef data_t = logic signed [DATA_WIDTH-1:0].
//   - rd_state_e enum {IDLE, STREAM, DRAIN}.
//  Sub-module feed_bank (DATA_WIDTH, N, DEPTH), instantiated twice:
//   - Storage: DEPTH x N registers.
//   - Lane write port: we, vec_addr, lane_addr, data.
//   - Vector read port: combinational N-wide output.
//  Top level holds the write counter, the full flags, the read FSM and the output register mux.
// TESTING (N=4, DEPTH=8, DATA_WIDTH=16)
//  1 Reset: hold rst 2 cycles then release -> dout all 0, dout_en=0, rd_busy=0, wr_ready=1 on the first cycle after release.
//  2 Single tile:
//    - Stimulus: write words 0..31, then pulse rd_start.
//    - Cycles 1-8: dout[l]=4*i+l for vector i, dout_en=1.
//    - Cycles 9-11: dout=0, dout_en=1; tile_done on cycle 11; cycle 12: rd_busy=0.
//  3 Ping-pong:
//    - Write tile A (0..31), then tile B (100..131) while A streams -> wr_ready stays 1 throughout B.
//    - With both banks full, wr_ready=0 until the cycle after tile_done.
//    - A second rd_start then streams B: first vector 100,101,102,103.
//  4 Stall: rd_stall high during STREAM cycles 3-4 -> 2 cycles of dout_en=0 with dout held at vector 1.
//    All 8 vectors still appear in order; tile_done is delayed by 2 cycles.
//  5 Early request: rd_start after 31 of 32 words -> ignored, rd_busy stays 0.
//    Write word 32 and pulse rd_start again -> tile streams normally.
//  6 Reset mid-STREAM: assert rst at vector 4 -> next cycle dout_en=0, full=0, wr_ready=1 after release.
//    No tile_done pulse.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and default geometry for the systolic feed path.
package dnn_pkg;
  localparam int DNN_DATA_WIDTH = 16;
  localparam int DNN_N          = 4;
  localparam int DNN_DEPTH      = 8;

  typedef logic signed [DNN_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  // Address width that stays at least one bit wide for degenerate sizes.
  function automatic int addr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction
endpackage

// File: rtl/feed_bank.sv
// One tile of DEPTH x N words: lane-granular write port, whole-vector combinational read.
module feed_bank
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DNN_DATA_WIDTH,
  parameter int N          = DNN_N,
  parameter int DEPTH      = DNN_DEPTH,
  parameter int VEC_W      = addr_width(DEPTH),
  parameter int LANE_W     = addr_width(N)
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [VEC_W-1:0]             i_vec_addr,
  input  logic [LANE_W-1:0]            i_lane_addr,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic [VEC_W-1:0]             i_rd_addr,
  output logic signed [DATA_WIDTH-1:0] o_rd_vec [N-1:0]
);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH-1:0][N-1:0];

  // Storage is deliberately not reset; a tile is only read after it has been fully written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_vec_addr][i_lane_addr] <= i_data;
    end
  end

  // Whole-vector read of the addressed row.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      o_rd_vec[l] = r_mem[i_rd_addr][l];
    end
  end

endmodule

// File: rtl/skew_feed_buffer.sv
// Ping-pong staging buffer: serial words fill one bank while the other streams
// one vector per cycle, followed by N-1 zero vectors to drain the skew chain.
module skew_feed_buffer
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DNN_DATA_WIDTH,
  parameter int N          = DNN_N,
  parameter int DEPTH      = DNN_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_start,
  input  logic                         rd_stall,
  output logic                         rd_busy,
  output logic                         tile_done,
  output logic signed [DATA_WIDTH-1:0] dout [N-1:0],
  output logic                         dout_en
);

  localparam int VEC_W  = addr_width(DEPTH);
  localparam int LANE_W = addr_width(N);
  localparam int CNT_W  = addr_width(N * DEPTH);
  localparam int DR_W   = addr_width(N);
  localparam bit HAS_DRAIN = (N > 1);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(DEPTH - 1);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'((N > 1) ? (N - 2) : 0);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(N * DEPTH - 1);

  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [1:0]                   r_full;
  logic [CNT_W-1:0]             r_wr_cnt;
  rd_state_e                    r_state;
  rd_state_e                    w_state_nxt;
  logic [VEC_W-1:0]             r_vec;
  logic [DR_W-1:0]              r_drain;
  logic signed [DATA_WIDTH-1:0] r_dout [N-1:0];
  logic                         r_dout_en;
  logic                         r_tile_done;

  logic                         w_wr_ready;
  logic                         w_wr_fire;
  logic                         w_wr_last;
  logic [VEC_W-1:0]             w_wr_vec;
  logic [LANE_W-1:0]            w_wr_lane;
  logic [1:0]                   w_full_set;
  logic [1:0]                   w_full_clr;
  logic [1:0]                   w_full_nxt;
  logic signed [DATA_WIDTH-1:0] w_bank0_vec [N-1:0];
  logic signed [DATA_WIDTH-1:0] w_bank1_vec [N-1:0];
  logic signed [DATA_WIDTH-1:0] w_rd_vec    [N-1:0];
  logic                         w_start;
  logic                         w_vec_last;
  logic                         w_drain_last;
  logic signed [DATA_WIDTH-1:0] w_dout_nxt  [N-1:0];
  logic                         w_dout_en_nxt;
  logic                         w_tile_done_nxt;
  logic                         w_tile_end;
  logic [VEC_W-1:0]             w_vec_nxt;
  logic [DR_W-1:0]              w_drain_nxt;

  assign w_wr_ready = !rst && !r_full[r_wr_bank];
  assign w_wr_fire  = wr_valid && w_wr_ready;
  assign w_wr_last  = (r_wr_cnt == WORD_LAST);
  assign w_wr_vec   = VEC_W'(r_wr_cnt / CNT_W'(N));
  assign w_wr_lane  = LANE_W'(r_wr_cnt % CNT_W'(N));

  // A bank is released one cycle after tile_done, so wr_ready rises the cycle after the pulse.
  assign w_full_set = {2{w_wr_fire && w_wr_last}} & (r_wr_bank ? 2'b10 : 2'b01);
  assign w_full_clr = {2{r_tile_done}} & (r_rd_bank ? 2'b01 : 2'b10);
  assign w_full_nxt = (r_full | w_full_set) & ~w_full_clr;

  assign w_start      = rd_start && r_full[r_rd_bank];
  assign w_vec_last   = (r_vec == VEC_LAST);
  assign w_drain_last = (r_drain == DRAIN_LAST);

  // Write counter and bank selector; the last word flips to the other bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= {CNT_W{1'b0}};
      r_full    <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire && w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_cnt  <= {CNT_W{1'b0}};
      end else if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end else begin
        r_wr_cnt <= r_wr_cnt;
      end
    end
  end

  feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .DEPTH(DEPTH), .VEC_W(VEC_W), .LANE_W(LANE_W)) u_bank0 (
    .clk(clk), .i_we(w_wr_fire && !r_wr_bank), .i_vec_addr(w_wr_vec), .i_lane_addr(w_wr_lane),
    .i_data(wr_data), .i_rd_addr(r_vec), .o_rd_vec(w_bank0_vec)
  );

  feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .DEPTH(DEPTH), .VEC_W(VEC_W), .LANE_W(LANE_W)) u_bank1 (
    .clk(clk), .i_we(w_wr_fire && r_wr_bank), .i_vec_addr(w_wr_vec), .i_lane_addr(w_wr_lane),
    .i_data(wr_data), .i_rd_addr(r_vec), .o_rd_vec(w_bank1_vec)
  );

  // Select the vector of the bank currently being streamed.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      w_rd_vec[l] = r_rd_bank ? w_bank1_vec[l] : w_bank0_vec[l];
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next-state logic; a stall freezes STREAM and DRAIN in place.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_start ? STREAM : IDLE;
      STREAM: begin
        if (rd_stall) begin
          w_state_nxt = STREAM;
        end else if (w_vec_last) begin
          w_state_nxt = HAS_DRAIN ? DRAIN : IDLE;
        end else begin
          w_state_nxt = STREAM;
        end
      end
      DRAIN: begin
        if (!rd_stall && w_drain_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read FSM outputs: next values of the registered vector, enable and counters.
  always_comb begin
    w_dout_nxt      = r_dout;
    w_dout_en_nxt   = 1'b0;
    w_tile_done_nxt = 1'b0;
    w_tile_end      = 1'b0;
    w_vec_nxt       = r_vec;
    w_drain_nxt     = r_drain;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_vec_nxt   = {VEC_W{1'b0}};
          w_drain_nxt = {DR_W{1'b0}};
        end else begin
          w_vec_nxt = r_vec;
        end
      end
      STREAM: begin
        if (!rd_stall) begin
          w_dout_nxt      = w_rd_vec;
          w_dout_en_nxt   = 1'b1;
          w_vec_nxt       = r_vec + VEC_W'(1);
          w_tile_end      = w_vec_last && !HAS_DRAIN;
          w_tile_done_nxt = w_vec_last && !HAS_DRAIN;
        end else begin
          w_dout_en_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (!rd_stall) begin
          for (int l = 0; l < N; l++) begin
            w_dout_nxt[l] = '0;
          end
          w_dout_en_nxt   = 1'b1;
          w_drain_nxt     = r_drain + DR_W'(1);
          w_tile_end      = w_drain_last;
          w_tile_done_nxt = w_drain_last;
        end else begin
          w_dout_en_nxt = 1'b0;
        end
      end
      default: w_dout_en_nxt = 1'b0;
    endcase
  end

  // Registered read datapath and read-bank pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < N; l++) begin
        r_dout[l] <= '0;
      end
      r_dout_en   <= 1'b0;
      r_tile_done <= 1'b0;
      r_vec       <= {VEC_W{1'b0}};
      r_drain     <= {DR_W{1'b0}};
      r_rd_bank   <= 1'b0;
    end else begin
      r_dout      <= w_dout_nxt;
      r_dout_en   <= w_dout_en_nxt;
      r_tile_done <= w_tile_done_nxt;
      r_vec       <= w_vec_nxt;
      r_drain     <= w_drain_nxt;
      r_rd_bank   <= r_rd_bank ^ w_tile_end;
    end
  end

  assign wr_ready  = w_wr_ready;
  assign rd_busy   = (r_state != IDLE);
  assign tile_done = r_tile_done;
  assign dout      = r_dout;
  assign dout_en   = r_dout_en;

endmodule
